// File: rtl/fp_pkg.sv
// Shared constants, state encoding and adder helpers
// for the fp32 to int32 conversion path.
package fp_pkg;

  localparam int FP_BIAS = 127;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    SIGN,
    DONE
  } state_t;

  function automatic logic [31:0] ripple_add32(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        ci
  );
    logic [31:0] s;
    logic        c;
    c = ci;
    for (int i = 0; i < 32; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return s;
  endfunction

  // a + (~b + 1): carry-in of one folds the increment into the ripple
  function automatic logic [8:0] comp_add9(
    input logic [8:0] a,
    input logic [8:0] b
  );
    logic [8:0] s;
    logic [8:0] nb;
    logic       c;
    nb = ~b;
    c  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      s[i] = a[i] ^ nb[i] ^ c;
      c    = (a[i] & nb[i]) | (c & (a[i] ^ nb[i]));
    end
    return s;
  endfunction

endpackage

// File: rtl/twos_negate_32bit.sv
// Combinational two's-complement negate: ~a + 1.
// Built on the shared ripple adder.
module twos_negate_32bit
  import fp_pkg::*;
(
  input  logic [31:0] a,
  output logic [31:0] y
);

  assign y = ripple_add32(~a, 32'd0, 1'b1);

endmodule

// File: rtl/fp32_to_int32_seq.sv
// Sequential fp32 -> int32 converter, truncating toward zero.
// Aligns the significand one bit per cycle.
module fp32_to_int32_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] fp_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] int_out,
  output logic        overflow,
  output logic        invalid
);

  state_t state_q, state_d;

  logic [31:0] fp_q;
  logic [31:0] mag_q;
  logic [4:0]  k_q;
  logic        left_q;
  logic [31:0] neg_mag;

  logic              sgn;
  logic [EXP_W-1:0]  ex;
  logic [FRAC_W-1:0] fr;
  logic [8:0]        e;
  logic              cls_inv;
  logic              cls_zero;
  logic              cls_ovf;
  logic              left_c;
  logic [4:0]        k_c;

  assign sgn = fp_q[31];
  assign ex  = fp_q[FRAC_W +: EXP_W];
  assign fr  = fp_q[FRAC_W-1:0];
  assign e   = comp_add9({1'b0, ex}, 9'(FP_BIAS));

  // e is a 9-bit signed value; bit 8 set means negative
  assign cls_inv  = (ex == 8'hFF);
  assign cls_zero = (ex == 8'h00) || e[8];
  assign cls_ovf  = (!e[8] && (e[7:5] != 3'b000)) ||
                    ((e == 9'd31) && !(sgn && (fr == '0)));
  assign left_c   = (e[7:0] >= 8'd23);
  assign k_c      = left_c ? 5'(e[4:0] - 5'd23)
                           : 5'(5'd23 - e[4:0]);

  twos_negate_32bit u_neg (
    .a (mag_q),
    .y (neg_mag)
  );

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        if (cls_inv || cls_zero || cls_ovf)
          state_d = DONE;
        else if (k_c != 5'd0)
          state_d = SHIFT;
        else
          state_d = SIGN;
      end
      SHIFT: if (k_q == 5'd1) state_d = SIGN;
      SIGN:  state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fp_q     <= '0;
      mag_q    <= '0;
      k_q      <= '0;
      left_q   <= 1'b0;
      int_out  <= '0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            fp_q     <= fp_in;
            int_out  <= '0;
            overflow <= 1'b0;
            invalid  <= 1'b0;
          end
        end
        LOAD: begin
          if (cls_inv) begin
            invalid <= 1'b1;
            // only -Inf saturates low; NaN of either sign goes high
            int_out <= (sgn && (fr == '0)) ? INT_MIN : INT_MAX;
          end else if (cls_zero) begin
            int_out <= '0;
          end else if (cls_ovf) begin
            overflow <= 1'b1;
            int_out  <= sgn ? INT_MIN : INT_MAX;
          end else begin
            mag_q  <= {8'b0, 1'b1, fr};
            k_q    <= k_c;
            left_q <= left_c;
          end
        end
        SHIFT: begin
          mag_q <= left_q ? (mag_q << 1) : (mag_q >> 1);
          k_q   <= k_q - 5'd1;
        end
        SIGN: int_out <= sgn ? neg_mag : mag_q;
        default: ;
      endcase
    end
  end

endmodule
